// File: rtl/fsmd_job_scheduler.sv
// ---------------------------------------------------------------------------
// fsmd_job_scheduler
//
// Shares a single FSM+D datapath (R1/R2/R3, one adder, one multiplier) among
// NREQ requesters. Each job is won by round-robin arbitration. The winner's
// five operands are latched, and the datapath is stepped through a fixed
// five-step schedule. The final R1 value is then returned together with the
// requester index. The datapath computes (a+b+c)*e mod 2^RWIDTH.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req[NREQ]           level request per requester
//   ops_in              packed operands; requester i at [i*5W +: 5W], {a,b,c,d,e}
//   gnt[NREQ]           registered one-hot grant, high for the S0 cycle only
//   a..e                operands latched at the grant edge, drive the datapath
//   sel1..3, ldR1..3    datapath mux selects / load enables (decoded from state)
//   r1_in               datapath R1, captured in WB
//   busy                state != IDLE
//   done, done_id       one-cycle completion pulse and requester index
//   result              captured R1, held until the next completion
//   state               current FSM state (debug)
// ---------------------------------------------------------------------------
module fsmd_job_scheduler #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*5*WIDTH-1:0]   ops_in,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          a,
  output logic [WIDTH-1:0]          b,
  output logic [WIDTH-1:0]          c,
  output logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          e,
  output logic [1:0]                sel1,
  output logic [1:0]                sel2,
  output logic [1:0]                sel3,
  output logic                      ldR1,
  output logic                      ldR2,
  output logic                      ldR3,
  input  logic [RWIDTH-1:0]         r1_in,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [RWIDTH-1:0]         result,
  output logic [2:0]                state
);

  localparam int ID_W = $clog2(NREQ);
  localparam int OPW  = 5 * WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5,
    WB   = 3'd6
  } state_e;

  state_e              state_q,   state_d;
  logic [ID_W-1:0]     rr_ptr_q,  rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q,  cur_id_d;
  logic [NREQ-1:0]     gnt_q,     gnt_d;
  logic                done_q,    done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [RWIDTH-1:0]   result_q,  result_d;
  logic [WIDTH-1:0]    a_q, b_q, c_q, d_q, e_q;
  logic [WIDTH-1:0]    a_d, b_d, c_d, d_d, e_d;

  // Arbitration results
  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_idx;
  logic [ID_W-1:0]     next_ptr;
  logic [OPW-1:0]      win_ops;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: scan upward from rr_ptr with wrap and take the first
  // set request bit. The index is advanced with an explicit wrap so that
  // NREQ values that are not powers of two also wrap correctly.
  // -------------------------------------------------------------------------
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
      scan_idx = (scan_idx == ID_W'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign next_ptr = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // Operand mux for the winning requester
  always_comb begin
    win_ops = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_ops = ops_in[i*OPW +: OPW];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_id_d  = cur_id_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    e_d       = e_q;

    case (state_q)
      IDLE: begin
        // Operands are sampled only here, at the grant edge.
        if (win_vld) begin
          state_d  = S0;
          gnt_d    = NREQ'(1) << win_id;
          cur_id_d = win_id;
          rr_ptr_d = next_ptr;
          {a_d, b_d, c_d, d_d, e_d} = win_ops;
        end
      end
      S0: state_d = S1;
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S4;
      S4: state_d = WB;
      WB: begin
        result_d  = r1_in;
        done_d    = 1'b1;
        done_id_d = cur_id_q;
        state_d   = IDLE;
      end
      // The unused encoding falls back to IDLE.
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      cur_id_q  <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      e_q       <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_id_q  <= cur_id_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      e_q       <= e_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath control, decoded directly from the current state.
  //   S0: R1=a,       R2=c
  //   S1: R1=R1+R2,   R3=d
  //   S2: R2=R2+R3,   R3=b
  //   S3: R1=R1+R3,   R2=R1*R2, R3=e
  //   S4: R1=R1*R3    -> (a+b+c)*e
  // The R2 updates in S2/S3 are not needed for the result. They are part
  // of the fixed schedule that the datapath expects.
  // -------------------------------------------------------------------------
  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    sel3 = 2'b00;
    ldR1 = 1'b0;
    ldR2 = 1'b0;
    ldR3 = 1'b0;
    case (state_q)
      S0: begin
        sel1 = 2'b11;
        sel2 = 2'b10;
        ldR1 = 1'b1;
        ldR2 = 1'b1;
      end
      S1: begin
        sel1 = 2'b10;
        sel3 = 2'b01;
        ldR1 = 1'b1;
        ldR3 = 1'b1;
      end
      S2: begin
        sel2 = 2'b01;
        sel3 = 2'b10;
        ldR2 = 1'b1;
        ldR3 = 1'b1;
      end
      S3: begin
        sel1 = 2'b01;
        sel2 = 2'b00;
        sel3 = 2'b00;
        ldR1 = 1'b1;
        ldR2 = 1'b1;
        ldR3 = 1'b1;
      end
      S4: begin
        sel1 = 2'b00;
        ldR1 = 1'b1;
      end
      default: begin
        sel1 = 2'b00;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign d       = d_q;
  assign e       = e_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign state   = state_q;

endmodule

// File: tb/tb_fsmd_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fsmd_job_scheduler
//
// Directed bench for fsmd_job_scheduler (NREQ=4, WIDTH=4, RWIDTH=8). A small
// register-transfer model of the R1/R2/R3 datapath is attached to the
// scheduler's selects, enables and operands, and it feeds r1_in. The
// expected values are hand-computed constants and tables.
// ---------------------------------------------------------------------------
module tb_fsmd_job_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int RW   = 8;
  localparam int OPW  = 5 * W;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*OPW-1:0]   ops_in;
  logic [NREQ-1:0]       gnt;
  logic [W-1:0]          a, b, c, d, e;
  logic [1:0]            sel1, sel2, sel3;
  logic                  ldR1, ldR2, ldR3;
  logic [RW-1:0]         r1_in;
  logic                  busy;
  logic                  done;
  logic [1:0]            done_id;
  logic [RW-1:0]         result;
  logic [2:0]            state;

  int n_chk  = 0;
  int n_pass = 0;

  fsmd_job_scheduler #(.NREQ(NREQ), .WIDTH(W), .RWIDTH(RW)) dut (
    .clock(clock), .reset(reset), .req(req), .ops_in(ops_in), .gnt(gnt),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .ldR1(ldR1), .ldR2(ldR2), .ldR3(ldR3),
    .r1_in(r1_in), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Datapath attached to the scheduler
  logic [RW-1:0] r1, r2, r3;
  always_ff @(posedge clock) begin
    if (ldR1) begin
      case (sel1)
        2'b11:   r1 <= RW'(a);
        2'b10:   r1 <= r1 + r2;
        2'b01:   r1 <= r1 + r3;
        default: r1 <= r1 * r3;
      endcase
    end
    if (ldR2) begin
      case (sel2)
        2'b10:   r2 <= RW'(c);
        2'b01:   r2 <= r2 + r3;
        default: r2 <= r1 * r2;
      endcase
    end
    if (ldR3) begin
      case (sel3)
        2'b01:   r3 <= RW'(d);
        2'b10:   r3 <= RW'(b);
        default: r3 <= RW'(e);
      endcase
    end
  end
  assign r1_in = r1;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] gn;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] s3;
    logic [2:0] ld;    // {ldR1, ldR2, ldR3}
    logic       bsy;
    logic       dn;
  } ctl_t;

  typedef struct packed {
    logic [1:0]     id;
    logic [OPW-1:0] ops;
    logic [RW-1:0]  res;
  } job_t;

  ctl_t ctl_tab [1:7];
  job_t jobs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [OPW-1:0] pk(input logic [3:0] pa, input logic [3:0] pb,
                                        input logic [3:0] pc, input logic [3:0] pd,
                                        input logic [3:0] pe);
    return {pa, pb, pc, pd, pe};
  endfunction

  task automatic set_ops(input int i, input logic [OPW-1:0] v);
    ops_in[i*OPW +: OPW] = v;
  endtask

  logic [OPW-1:0] ops0, ops1, ops2, ops3;
  int gnt_cnt, gnt3_cnt, done_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    req    = '0;
    ops_in = '0;

    ops0 = pk(4'd1,  4'd2,  4'd3,  4'd4, 4'd5);   // 6*5   = 30
    ops1 = pk(4'd2,  4'd3,  4'd4,  4'd1, 4'd6);   // 9*6   = 54
    ops2 = pk(4'd15, 4'd15, 4'd15, 4'd0, 4'd15);  // 45*15 = 675 mod 256 = 163
    ops3 = pk(4'd7,  4'd0,  4'd1,  4'd9, 4'd3);   // 8*3   = 24

    //                st    gnt      s1     s2     s3     ld      bsy   dn
    ctl_tab[1] = '{3'd1, 4'b0001, 2'b11, 2'b10, 2'b00, 3'b110, 1'b1, 1'b0};
    ctl_tab[2] = '{3'd2, 4'b0000, 2'b10, 2'b00, 2'b01, 3'b101, 1'b1, 1'b0};
    ctl_tab[3] = '{3'd3, 4'b0000, 2'b00, 2'b01, 2'b10, 3'b011, 1'b1, 1'b0};
    ctl_tab[4] = '{3'd4, 4'b0000, 2'b01, 2'b00, 2'b00, 3'b111, 1'b1, 1'b0};
    ctl_tab[5] = '{3'd5, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0};
    ctl_tab[6] = '{3'd6, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
    ctl_tab[7] = '{3'd0, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};

    jobs[0] = '{2'd0, ops0, 8'd30};
    jobs[1] = '{2'd1, ops1, 8'd54};
    jobs[2] = '{2'd2, ops2, 8'd163};
    jobs[3] = '{2'd3, ops3, 8'd24};
    jobs[4] = '{2'd0, ops0, 8'd30};

    // ---- Reset state ----
    do_reset();
    check("rst_state",   32'(state),   32'(0));
    check("rst_gnt",     32'(gnt),     32'(0));
    check("rst_done",    32'(done),    32'(0));
    check("rst_done_id", 32'(done_id), 32'(0));
    check("rst_result",  32'(result),  32'(0));
    check("rst_ops",     32'({a, b, c, d, e}), 32'(0));
    check("rst_ctl",     32'({sel1, sel2, sel3, ldR1, ldR2, ldR3}), 32'(0));
    check("rst_busy",    32'(busy),    32'(0));

    // ---- Single job from requester 0, per-cycle control table ----
    set_ops(0, ops0);
    req = 4'b0001;
    for (int cy = 1; cy <= 7; cy++) begin
      tick();
      check($sformatf("t1_state_c%0d", cy), 32'(state), 32'(ctl_tab[cy].st));
      check($sformatf("t1_gnt_c%0d", cy),   32'(gnt),   32'(ctl_tab[cy].gn));
      check($sformatf("t1_sel1_c%0d", cy),  32'(sel1),  32'(ctl_tab[cy].s1));
      check($sformatf("t1_sel2_c%0d", cy),  32'(sel2),  32'(ctl_tab[cy].s2));
      check($sformatf("t1_sel3_c%0d", cy),  32'(sel3),  32'(ctl_tab[cy].s3));
      check($sformatf("t1_ld_c%0d", cy),    32'({ldR1, ldR2, ldR3}), 32'(ctl_tab[cy].ld));
      check($sformatf("t1_busy_c%0d", cy),  32'(busy),  32'(ctl_tab[cy].bsy));
      check($sformatf("t1_done_c%0d", cy),  32'(done),  32'(ctl_tab[cy].dn));
      if (cy == 1) begin
        check("t1_ops_latched", 32'({a, b, c, d, e}), 32'(ops0));
        req = 4'b0000;
      end
    end
    check("t1_done_id", 32'(done_id), 32'(0));
    check("t1_result",  32'(result),  32'(30));
    tick();
    check("t1_done_drop",  32'(done),   32'(0));
    check("t1_result_hold", 32'(result), 32'(30));
    check("t1_idle_state", 32'(state),  32'(0));

    // ---- Round robin with all four requesting continuously ----
    do_reset();
    set_ops(0, ops0);
    set_ops(1, ops1);
    set_ops(2, ops2);
    set_ops(3, ops3);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr_gnt_j%0d", j), 32'(gnt), 32'(4'b0001 << jobs[j].id));
      check($sformatf("rr_ops_j%0d", j), 32'({a, b, c, d, e}), 32'(jobs[j].ops));
      for (int k = 0; k < 5; k++) tick();
      tick();
      check($sformatf("rr_done_j%0d", j),    32'(done),    32'(1));
      check($sformatf("rr_done_id_j%0d", j), 32'(done_id), 32'(jobs[j].id));
      check($sformatf("rr_result_j%0d", j),  32'(result),  32'(jobs[j].res));
    end
    req = 4'b0000;

    // ---- Requests arriving while busy ----
    do_reset();
    set_ops(0, ops0);
    set_ops(1, ops1);
    set_ops(2, ops2);
    req = 4'b0001;
    tick();                                  // cycle 1
    check("lr_gnt0", 32'(gnt), 32'(4'b0001));
    req = 4'b0000;
    tick();                                  // cycle 2
    req = 4'b0100;
    tick();                                  // cycle 3
    check("lr_no_early_latch", 32'({a, b, c, d, e}), 32'(ops0));
    check("lr_no_gnt_busy",    32'(gnt),             32'(0));
    tick();                                  // cycle 4
    req = 4'b0110;
    tick();
    tick();
    tick();                                  // cycle 7
    check("lr_done0",    32'(done),    32'(1));
    check("lr_done_id0", 32'(done_id), 32'(0));
    check("lr_result0",  32'(result),  32'(30));
    tick();                                  // cycle 8
    check("lr_gnt1", 32'(gnt),             32'(4'b0010));
    check("lr_ops1", 32'({a, b, c, d, e}), 32'(ops1));
    req = 4'b0100;
    for (int k = 0; k < 6; k++) tick();      // cycle 14
    check("lr_done_id1", 32'(done_id), 32'(1));
    check("lr_result1",  32'(result),  32'(54));
    tick();                                  // cycle 15
    check("lr_gnt2", 32'(gnt),             32'(4'b0100));
    check("lr_ops2", 32'({a, b, c, d, e}), 32'(ops2));
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();      // cycle 21
    check("lr_done2",    32'(done),    32'(1));
    check("lr_done_id2", 32'(done_id), 32'(2));
    check("lr_result2",  32'(result),  32'(163));

    // ---- Reset asserted in S3 ----
    do_reset();
    set_ops(0, ops0);
    set_ops(1, ops1);
    req = 4'b0001;
    tick();                                  // cycle 1
    req = 4'b0000;
    tick();
    tick();
    tick();                                  // cycle 4
    check("ra_in_s3", 32'(state), 32'(4));
    reset = 1'b1;
    tick();                                  // cycle 5
    reset = 1'b0;
    check("ra_state", 32'(state), 32'(0));
    check("ra_ld",    32'({ldR1, ldR2, ldR3}), 32'(0));
    check("ra_gnt",   32'(gnt),   32'(0));
    check("ra_done5", 32'(done),  32'(0));
    tick();
    check("ra_done6", 32'(done), 32'(0));
    tick();
    check("ra_done7", 32'(done), 32'(0));
    // rr_ptr must be back at 0: requesters 0 and 1 both ask, 0 must win.
    req = 4'b0011;
    tick();
    check("ra_regnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
    check("ra_redone",    32'(done),    32'(1));
    check("ra_redone_id", 32'(done_id), 32'(0));
    check("ra_reresult",  32'(result),  32'(30));

    // ---- One-cycle request pulse while busy ----
    do_reset();
    set_ops(0, ops0);
    set_ops(3, ops3);
    req      = 4'b0001;
    gnt_cnt  = 0;
    gnt3_cnt = 0;
    done_cnt = 0;
    for (int cy = 1; cy <= 16; cy++) begin
      tick();
      if (gnt != 0) gnt_cnt++;
      if (gnt[3])   gnt3_cnt++;
      if (done)     done_cnt++;
      if (cy == 1) req = 4'b0000;
      if (cy == 3) req = 4'b1000;
      if (cy == 4) req = 4'b0000;
    end
    check("pulse_gnt3_count", 32'(gnt3_cnt), 32'(0));
    check("pulse_gnt_count",  32'(gnt_cnt),  32'(1));
    check("pulse_done_count", 32'(done_cnt), 32'(1));
    check("pulse_done_id",    32'(done_id),  32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fsmd_job_scheduler.md
Name: fsmd_job_scheduler

Overview:
- Shares one FSM+D datapath among NREQ requesters.
- The datapath has three registers R1/R2/R3, 2-bit selects sel1/sel2/sel3, load enables ldR1/ldR2/ldR3, one adder and one multiplier.
- Per job, the block arbitrates round-robin, latches the winner's five operands, sequences the datapath through the fixed 5-step schedule, captures R1 and returns it with the requester ID.
- Each job computes result = (a+b+c)*e mod 2^RWIDTH.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width.
- RWIDTH, 8, datapath register/result width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester; operands must be stable while high
- ops_in  in  NREQ*5*WIDTH  operands; requester i occupies bits [i*5W +: 5W], ordered {a,b,c,d,e} with a at the MSB end
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- a, b, c, d, e  out  WIDTH each  latched operands driven to the datapath
- sel1, sel2, sel3  out  2 each  datapath mux selects
- ldR1, ldR2, ldR3  out  1 each  datapath load enables
- r1_in  in  RWIDTH  datapath R1 value
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle result-valid pulse
- done_id  out  $clog2(NREQ)  requester index of the completed job
- result  out  RWIDTH  captured R1
- state  out  3  current state, for debug

Behaviour:
- Reset is synchronous and active-high. It forces:
  - state=IDLE, rr_ptr=0, gnt=0, done=0, done_id=0, result=0
  - a..e=0, all sel=00, all ld=0
- Reset mid-job aborts the job: no done, no gnt, and the requester must re-request.
- States (encoding): IDLE=0, S0=1, S1=2, S2=3, S3=4, S4=5, WB=6. Code 7 returns to IDLE.
- IDLE:
  - If req != 0, pick the first set bit scanning upward from rr_ptr with wrap.
  - At the next edge: latch the winner's operands into a..e, set gnt=onehot(winner), set cur_id=winner, set rr_ptr=(winner+1) mod NREQ, go to S0.
  - If req == 0, stay in IDLE.
- gnt is registered: high only during the S0 cycle. The requester may drop req from that cycle on.
- Datapath control is combinational from state. Anything not listed is sel=00, ld=0.
  - S0: sel1=11 (R1=a), sel2=10 (R2=c), ldR1=ldR2=1.
  - S1: sel1=10 (R1=R1+R2), sel3=01 (R3=d), ldR1=ldR3=1.
  - S2: sel2=01 (R2=R2+R3), sel3=10 (R3=b), ldR2=ldR3=1.
  - S3: sel1=01 (R1=R1+R3), sel2=00 (R2=R1*R2), sel3=00 (R3=e), all ld=1.
  - S4: sel1=00 (R1=R1*R3), ldR1=1.
  - IDLE, WB: all ld=0.
- S0→S1→S2→S3→S4→WB, unconditional, one cycle each.
- WB: r1_in holds the final R1. At the edge: result<=r1_in, done<=1, done_id<=cur_id, state<=IDLE.
- done is high during the following IDLE cycle only. result and done_id hold until the next WB.
- Latency and throughput:
  - req seen in IDLE at cycle 0 → gnt at cycle 1 → done at cycle 7.
  - With back-to-back requests, the next gnt comes at cycle 8. Arbitration runs in the same IDLE cycle that done is high, so throughput is one job per 7 cycles.
- Requests arriving while busy are held as level. They are neither lost nor latched early; operands are sampled only at the grant edge.
- A requester that drops req before its grant gets no job.
- Arithmetic wraps modulo 2^RWIDTH; this is the datapath's responsibility. The scheduler only captures r1_in.

Test Plan:
- Reset, then req=0001 with a=1,b=2,c=3,d=4,e=5; datapath model attached:
  - gnt=0001 in cycle 1.
  - sel/ld sequence exactly as the S0–S4 table in cycles 1–5.
  - done=1, done_id=0, result=30 in cycle 7; busy high in cycles 1–6.
- req=1111 held continuously, distinct operands per requester:
  - Grants in order 0,1,2,3,0, each 7 cycles apart.
  - Each done_id/result matches (a+b+c)*e of that requester.
- Overflow, RWIDTH=8, a=b=c=15, e=15: result=(45*15) mod 256=163.
- req[2] rises while busy with job 0; req[1] rises later, also before done; rr_ptr=1 after job 0:
  - Next grant goes to 1, then 2.
  - Operands are sampled at each grant edge, not when req rose.
- Reset asserted in S3:
  - Next cycle: state=IDLE, all ld=0, gnt=0, done stays 0, rr_ptr=0.
  - A re-issued request is then served normally.
- req pulsed for one cycle while busy and dropped before IDLE: no gnt and no done for that requester.
